// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared state encoding and port-index constants for the
//             two-port memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   // Arbiter sequencing states; one transaction walks IDLE->ISSUE->(WAIT)->RESP
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Requester indices (also the encoding of the owner / last-owner flags)
   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   // Latency counter width; read latency is limited to 0..7
   localparam int LAT_W = 3;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing one memory port between two
//             req/ack requesters, one transaction at a time, with a fixed
//             read latency. All memory-side and requester-side outputs are
//             registered.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_dout
);

   // WAIT counts down from here to zero, so the total extra wait is RD_LAT
   localparam logic [LAT_W-1:0] LAT_LOAD = (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic                last_owner_q, last_owner_d;
   logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                ack0_q, ack0_d, ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q, mem_din_d;
   logic                mem_write_q, mem_write_d;

   logic                pick;
   logic                to_resp;
   logic                capture;

   // Round-robin choice: a tie goes to the port that did not own memory last
   function automatic logic pick_owner(input logic r0, input logic r1, input logic last);
      if (r0 && r1) begin
         return ~last;
      end
      return r1 ? P1 : P0;
   endfunction

   // Next-state and registered-output computation for the transaction sequencer
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      lat_cnt_d    = lat_cnt_q;
      last_owner_d = last_owner_q;
      gnt0_d       = gnt0_q;
      gnt1_d       = gnt1_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      mem_write_d  = 1'b0;
      to_resp      = 1'b0;
      capture      = 1'b0;
      pick         = pick_owner(req0, req1, last_owner_q);

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d      = pick;
               we_d         = (pick == P1) ? we1 : we0;
               mem_addr_d   = (pick == P1) ? addr1 : addr0;
               mem_din_d    = (pick == P1) ? wdata1 : wdata0;
               mem_write_d  = (pick == P1) ? we1 : we0;
               gnt0_d       = (pick == P0);
               gnt1_d       = (pick == P1);
               last_owner_d = pick;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               to_resp = 1'b1;
            end else if (RD_LAT == 0) begin
               capture = 1'b1;
               to_resp = 1'b1;
            end else begin
               lat_cnt_d = LAT_LOAD;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end else begin
               capture = 1'b1;
               to_resp = 1'b1;
            end
         end
         RESP: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (to_resp) begin
         state_d = RESP;
         ack0_d  = (owner_q == P0);
         ack1_d  = (owner_q == P1);
      end

      if (capture) begin
         if (owner_q == P0) begin
            rdata0_d = mem_dout;
         end else begin
            rdata1_d = mem_dout;
         end
      end
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= P0;
         we_q         <= 1'b0;
         lat_cnt_q    <= '0;
         last_owner_q <= P1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         mem_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         lat_cnt_q    <= lat_cnt_d;
         last_owner_q <= last_owner_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign mem_write = mem_write_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Randomised self-checking bench for mem_arbiter. Three DUTs with
//             read latencies 0, 1 and 3 each get their own memory stub,
//             random requesters/resets and a transaction-schedule reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int N_CYC = 3000;

   logic clk;
   int   n_vec = 0;
   int   n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check, reports any mismatch
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Initial memory image shared by the stub and the reference copy
   function automatic logic [7:0] init_val(input int k);
      return 8'((k * 29) ^ 8'h5A);
   endfunction

   // Random requester: holds req until ack, may re-request at once, may
   // scribble on addr/data while waiting, may drop req while granted
   task automatic drive_port(input logic ack, input logic gnt, input int rate,
                             inout logic req, inout logic we,
                             inout logic [7:0] addr, inout logic [7:0] wdata);
      if (ack) req = 1'b0;
      if (!req) begin
         if (int'($urandom_range(0, 99)) < rate) begin
            req   = 1'b1;
            we    = 1'($urandom_range(0, 1));
            addr  = 8'($urandom_range(0, 15));
            wdata = 8'($urandom);
         end
      end else begin
         if ($urandom_range(0, 7) == 0) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 8'($urandom_range(0, 15));
            wdata = 8'($urandom);
         end
         if (gnt && $urandom_range(0, 9) == 0) req = 1'b0;
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;

      logic       reset;
      logic       req0, we0, gnt0, ack0, req1, we1, gnt1, ack1, mem_write;
      logic [7:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
      logic [7:0] mem_addr, mem_din, mem_dout;
      logic [7:0] mem [256];
      logic [7:0] pipe [1:3];
      bit         mem_ready;

      mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .req0     (req0),
         .we0      (we0),
         .addr0    (addr0),
         .wdata0   (wdata0),
         .gnt0     (gnt0),
         .ack0     (ack0),
         .rdata0   (rdata0),
         .req1     (req1),
         .we1      (we1),
         .addr1    (addr1),
         .wdata1   (wdata1),
         .gnt1     (gnt1),
         .ack1     (ack1),
         .rdata1   (rdata1),
         .mem_addr (mem_addr),
         .mem_din  (mem_din),
         .mem_write(mem_write),
         .mem_dout (mem_dout)
      );

      // Memory stub: synchronous write, LAT-stage read pipeline (or async for 0)
      always @(posedge clk) begin
         if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
            mem_ready <= 1'b1;
         end else if (mem_write) begin
            mem[mem_addr] <= mem_din;
         end
         pipe[1] <= mem[mem_addr];
         for (int k = 2; k <= 3; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_dout = (LAT == 0) ? mem[mem_addr] : pipe[(LAT == 0) ? 1 : LAT];

      // Reference: schedule of each granted transaction in edge numbers;
      // grant at edge g, ack after edge r = g+1(+LAT for reads), next grant >= r+2
      initial begin
         int         e, g, r, free_at, rate;
         logic       m_owner, m_we, m_last;
         logic [7:0] m_addr, m_wdata, m_rd0, m_rd1;
         logic [7:0] ref_mem [256];
         bit         in_gnt;
         string      pfx;

         pfx = $sformatf("lat%0d", LAT);
         for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
         e = 0; g = -10; r = -10; free_at = 0;
         m_owner = 1'b0; m_we = 1'b0; m_last = 1'b1;
         m_addr = 8'h00; m_wdata = 8'h00; m_rd0 = 8'h00; m_rd1 = 8'h00;
         reset = 1'b1;
         req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
         req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;

         forever begin
            @(posedge clk);
            e++;
            if (reset) begin
               free_at = e + 1; g = -10; r = -10;
               m_last = 1'b1; m_we = 1'b0;
               m_addr = 8'h00; m_wdata = 8'h00; m_rd0 = 8'h00; m_rd1 = 8'h00;
            end else begin
               if (e == r && !m_we) begin
                  if (m_owner) m_rd1 = ref_mem[m_addr];
                  else         m_rd0 = ref_mem[m_addr];
               end
               if (e >= free_at && (req0 || req1)) begin
                  m_owner = (req0 && req1) ? ~m_last : req1;
                  m_last  = m_owner;
                  m_we    = m_owner ? we1    : we0;
                  m_addr  = m_owner ? addr1  : addr0;
                  m_wdata = m_owner ? wdata1 : wdata0;
                  g       = e;
                  r       = e + 1 + (m_we ? 0 : LAT);
                  free_at = r + 2;
                  if (m_we) ref_mem[m_addr] = m_wdata;
               end
            end

            @(negedge clk);
            in_gnt = (e >= g) && (e <= r);
            check_eq({pfx, " gnt0"},      32'(gnt0),      32'(in_gnt && !m_owner));
            check_eq({pfx, " gnt1"},      32'(gnt1),      32'(in_gnt &&  m_owner));
            check_eq({pfx, " ack0"},      32'(ack0),      32'(e == r && !m_owner));
            check_eq({pfx, " ack1"},      32'(ack1),      32'(e == r &&  m_owner));
            check_eq({pfx, " mem_write"}, 32'(mem_write), 32'(e == g && m_we));
            check_eq({pfx, " mem_addr"},  32'(mem_addr),  32'(m_addr));
            check_eq({pfx, " mem_din"},   32'(mem_din),   32'(m_wdata));
            check_eq({pfx, " rdata0"},    32'(rdata0),    32'(m_rd0));
            check_eq({pfx, " rdata1"},    32'(rdata1),    32'(m_rd1));

            // Alternate heavy contention with sparse traffic; rare resets
            reset = (e < 3) || ($urandom_range(0, 399) == 0);
            rate  = (((e / 400) % 2) == 0) ? 100 : 20;
            drive_port(ack0, gnt0, rate, req0, we0, addr0, wdata0);
            drive_port(ack1, gnt1, rate, req1, we1, addr1, wdata1);
         end
      end
   end

   initial begin
      repeat (N_CYC) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
